// File: rtl/ann_wbs_pkg.sv
// Address map, CSR offsets and region decode shared by the ANN Wishbone slave.
package ann_wbs_pkg;

  localparam logic [31:0] WBS_ADDR_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] WBS_CSR_ADDR   = 32'h3000_0000;
  localparam logic [31:0] WBS_QUERY_ADDR = 32'h3001_0000;
  localparam logic [31:0] WBS_LEAF_ADDR  = 32'h3002_0000;
  localparam logic [31:0] WBS_BEST_ADDR  = 32'h3003_0000;
  localparam logic [31:0] WBS_NODE_ADDR  = 32'h3004_0000;

  localparam logic [7:0] CSR_MODE      = 8'h00;
  localparam logic [7:0] CSR_DEBUG     = 8'h04;
  localparam logic [7:0] CSR_DONE      = 8'h08;
  localparam logic [7:0] CSR_FSM_START = 8'h0C;
  localparam logic [7:0] CSR_BUSY      = 8'h10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CSR,
    REG_QUERY,
    REG_LEAF,
    REG_BEST,
    REG_NODE
  } region_e;

  // Anything outside the five 64 KiB windows maps to REG_NONE and is acked harmlessly.
  function automatic region_e decode_region(input logic [31:0] adr);
    region_e r;
    case (adr & WBS_ADDR_MASK)
      WBS_CSR_ADDR:   r = REG_CSR;
      WBS_QUERY_ADDR: r = REG_QUERY;
      WBS_LEAF_ADDR:  r = REG_LEAF;
      WBS_BEST_ADDR:  r = REG_BEST;
      WBS_NODE_ADDR:  r = REG_NODE;
      default:        r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wbs_word_pair_stager.sv
// Pairs two 32-bit bus words into one wide SRAM write: the lower word is held,
// the upper word commits {upper, lower} and clears the holding register.
module wbs_word_pair_stager #(
  parameter int WIDTH = 64,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [AW-1:0]    entry,
  input  logic [31:0]      dat,
  output logic             we,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] wdata
);

  logic [31:0] hold_lo;

  // An upper write with no staged lower word commits zeros in the low half.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_lo <= '0;
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
    end else begin
      we <= wr_hi;
      if (wr_hi) begin
        addr    <= entry;
        wdata   <= WIDTH'({dat, hold_lo});
        hold_lo <= '0;
      end else if (wr_lo) begin
        hold_lo <= dat;
      end
    end
  end

endmodule

// File: rtl/wbs_ann_slave.sv
// Wishbone classic slave for the ANN block: CSRs, wide SRAM write staging,
// node writes and two-cycle BEST reads.
module wbs_ann_slave
  import ann_wbs_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int QUERY_AW   = 9,
  parameter int LEAF_AW    = 9,
  parameter int BEST_AW    = 9,
  parameter int NODE_AW    = 6
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic                    mode_o,
  output logic                    debug_o,
  output logic                    fsm_start_o,
  input  logic                    fsm_done_i,
  input  logic                    fsm_busy_i,
  output logic                    query_we_o,
  output logic [QUERY_AW-1:0]     query_addr_o,
  output logic [5*DATA_WIDTH-1:0] query_wdata_o,
  output logic                    leaf_we_o,
  output logic [LEAF_AW-1:0]      leaf_addr_o,
  output logic [63:0]             leaf_wdata_o,
  output logic                    node_we_o,
  output logic [NODE_AW-1:0]      node_addr_o,
  output logic [2*DATA_WIDTH-1:0] node_wdata_o,
  output logic                    best_re_o,
  output logic [BEST_AW-1:0]      best_addr_o,
  input  logic [63:0]             best_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_e;

  state_e      state;
  region_e     region;
  logic        req;
  logic        wr_req;
  logic        rd_req;
  logic [7:0]  csr_off;
  logic [31:0] csr_rdata;
  logic        done_q;
  logic        done_clr;
  logic        rd_half;
  logic        unused_bits;

  assign region   = decode_region(wbs_adr_i);
  assign csr_off  = wbs_adr_i[7:0];
  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (state == IDLE) & ~wb_rst_i;
  assign wr_req   = req & wbs_we_i;
  assign rd_req   = req & ~wbs_we_i;
  assign done_clr = wr_req & (region == REG_CSR) & (csr_off == CSR_DONE);

  // Read enable is combinational so the SRAM data is back one cycle after the request.
  assign best_re_o   = rd_req & (region == REG_BEST);
  assign best_addr_o = best_re_o ? wbs_adr_i[BEST_AW+2:3] : '0;

  assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[15:12]};

  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      CSR_MODE:  csr_rdata = {31'b0, mode_o};
      CSR_DEBUG: csr_rdata = {31'b0, debug_o};
      CSR_DONE:  csr_rdata = {31'b0, done_q};
      CSR_BUSY:  csr_rdata = {31'b0, fsm_busy_i};
      default:   csr_rdata = '0;
    endcase
  end

  wbs_word_pair_stager #(.WIDTH(5*DATA_WIDTH), .AW(QUERY_AW)) u_query_stager (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .wr_lo (wr_req & (region == REG_QUERY) & ~wbs_adr_i[2]),
    .wr_hi (wr_req & (region == REG_QUERY) & wbs_adr_i[2]),
    .entry (wbs_adr_i[QUERY_AW+2:3]),
    .dat   (wbs_dat_i),
    .we    (query_we_o),
    .addr  (query_addr_o),
    .wdata (query_wdata_o)
  );

  wbs_word_pair_stager #(.WIDTH(64), .AW(LEAF_AW)) u_leaf_stager (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .wr_lo (wr_req & (region == REG_LEAF) & ~wbs_adr_i[2]),
    .wr_hi (wr_req & (region == REG_LEAF) & wbs_adr_i[2]),
    .entry (wbs_adr_i[LEAF_AW+2:3]),
    .dat   (wbs_dat_i),
    .we    (leaf_we_o),
    .addr  (leaf_addr_o),
    .wdata (leaf_wdata_o)
  );

  // Every bus transaction passes through ACK exactly once, which also clears the pulses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      mode_o       <= 1'b0;
      debug_o      <= 1'b0;
      done_q       <= 1'b0;
      fsm_start_o  <= 1'b0;
      node_we_o    <= 1'b0;
      node_addr_o  <= '0;
      node_wdata_o <= '0;
      rd_half      <= 1'b0;
    end else begin
      if (fsm_done_i)
        done_q <= 1'b1;
      else if (done_clr)
        done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            if (!wbs_we_i && region == REG_BEST) begin
              rd_half <= wbs_adr_i[2];
              state   <= RD_WAIT;
            end else begin
              wbs_ack_o <= 1'b1;
              state     <= ACK;
              if (!wbs_we_i && region == REG_CSR)
                wbs_dat_o <= csr_rdata;
              if (wbs_we_i) begin
                case (region)
                  REG_CSR: begin
                    case (csr_off)
                      CSR_MODE:      mode_o      <= wbs_dat_i[0];
                      CSR_DEBUG:     debug_o     <= wbs_dat_i[0];
                      CSR_FSM_START: fsm_start_o <= ~fsm_busy_i;
                      default:       ;
                    endcase
                  end
                  REG_NODE: begin
                    node_we_o    <= 1'b1;
                    node_addr_o  <= wbs_adr_i[NODE_AW-1:0];
                    node_wdata_o <= wbs_dat_i[2*DATA_WIDTH-1:0];
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        RD_WAIT: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= rd_half ? best_rdata_i[63:32] : best_rdata_i[31:0];
          state     <= ACK;
        end
        ACK: begin
          wbs_ack_o   <= 1'b0;
          wbs_dat_o   <= '0;
          fsm_start_o <= 1'b0;
          node_we_o   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_ann_slave.sv
// Directed self-checking bench for wbs_ann_slave: CSRs, wide staging, node
// writes, BEST read latency, DONE/START behaviour and mid-read reset.
module tb_wbs_ann_slave;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        mode_o, debug_o, fsm_start_o;
  logic        fsm_done_i, fsm_busy_i;
  logic        query_we_o;
  logic [8:0]  query_addr_o;
  logic [54:0] query_wdata_o;
  logic        leaf_we_o;
  logic [8:0]  leaf_addr_o;
  logic [63:0] leaf_wdata_o;
  logic        node_we_o;
  logic [5:0]  node_addr_o;
  logic [21:0] node_wdata_o;
  logic        best_re_o;
  logic [8:0]  best_addr_o;
  logic [63:0] best_rdata_i = '0;

  int errors = 0;
  int checks = 0;
  int node_cnt = 0, leaf_cnt = 0, query_cnt = 0, start_cnt = 0;
  int base;

  wbs_ann_slave dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .mode_o        (mode_o),
    .debug_o       (debug_o),
    .fsm_start_o   (fsm_start_o),
    .fsm_done_i    (fsm_done_i),
    .fsm_busy_i    (fsm_busy_i),
    .query_we_o    (query_we_o),
    .query_addr_o  (query_addr_o),
    .query_wdata_o (query_wdata_o),
    .leaf_we_o     (leaf_we_o),
    .leaf_addr_o   (leaf_addr_o),
    .leaf_wdata_o  (leaf_wdata_o),
    .node_we_o     (node_we_o),
    .node_addr_o   (node_addr_o),
    .node_wdata_o  (node_wdata_o),
    .best_re_o     (best_re_o),
    .best_addr_o   (best_addr_o),
    .best_rdata_i  (best_rdata_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Synchronous-read model of the BEST SRAM; only entry 4 holds data.
  always @(posedge wb_clk_i)
    if (best_re_o)
      best_rdata_i <= (best_addr_o == 9'd4) ? 64'h0000_0007_0000_03E8 : 64'h0;

  always @(negedge wb_clk_i) begin
    if (node_we_o)   node_cnt++;
    if (leaf_we_o)   leaf_cnt++;
    if (query_we_o)  query_cnt++;
    if (fsm_start_o) start_cnt++;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
  endtask

  task automatic bus_start(input logic w, input logic [31:0] a, input logic [31:0] d);
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = w;
    wbs_adr_i = a;
    wbs_dat_i = d;
  endtask

  task automatic bus_stop();
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  // Returns in the ack cycle so the caller can inspect the write pulses.
  task automatic apply_stimulus(input string tag, input logic [31:0] a, input logic [31:0] d);
    bus_start(1'b1, a, d);
    tick();
    check_output({tag, "_ack"}, 64'(wbs_ack_o), 64'd1);
    bus_stop();
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_start(1'b0, a, 32'h0);
    tick();
    check_output({tag, "_ack"}, 64'(wbs_ack_o), 64'd1);
    check_output({tag, "_dat"}, 64'(wbs_dat_o), 64'(exp));
    bus_stop();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    wb_rst_i   = 1'b1;
    wbs_sel_i  = 4'hF;
    fsm_done_i = 1'b0;
    fsm_busy_i = 1'b0;
    bus_stop();
    wbs_adr_i  = '0;
    wbs_dat_i  = '0;
    repeat (3) tick();

    check_output("rst_ack",   64'(wbs_ack_o),   64'd0);
    check_output("rst_dat",   64'(wbs_dat_o),   64'd0);
    check_output("rst_mode",  64'(mode_o),      64'd0);
    check_output("rst_debug", 64'(debug_o),     64'd0);
    check_output("rst_start", 64'(fsm_start_o), 64'd0);
    check_output("rst_qwe",   64'(query_we_o),  64'd0);
    check_output("rst_nwe",   64'(node_we_o),   64'd0);
    check_output("rst_bre",   64'(best_re_o),   64'd0);
    wb_rst_i = 1'b0;
    tick();

    // DEBUG then MODE writes; MODE holds stb an extra cycle to see ack forced low.
    bus_start(1'b1, 32'h3000_0004, 32'h1);
    #1 check_output("dbg_ack_req", 64'(wbs_ack_o), 64'd0);
    tick();
    check_output("dbg_ack", 64'(wbs_ack_o), 64'd1);
    bus_stop();
    tick();
    check_output("dbg_ack_drop", 64'(wbs_ack_o), 64'd0);
    check_output("debug_o", 64'(debug_o), 64'd1);
    bus_start(1'b1, 32'h3000_0000, 32'h1);
    tick();
    check_output("mode_ack", 64'(wbs_ack_o), 64'd1);
    tick();
    check_output("mode_ack_forced_low", 64'(wbs_ack_o), 64'd0);
    bus_stop();
    tick();
    check_output("mode_o", 64'(mode_o), 64'd1);
    bus_read("rd_mode", 32'h3000_0000, 32'h1);
    bus_read("rd_debug", 32'h3000_0004, 32'h1);

    // NODE write {median=55, index=1}.
    base = node_cnt;
    apply_stimulus("node", 32'h3004_0005, 32'h0001_B801);
    check_output("node_we",    64'(node_we_o),    64'd1);
    check_output("node_addr",  64'(node_addr_o),  64'd5);
    check_output("node_wdata", 64'(node_wdata_o), 64'h1B801);
    tick();
    check_output("node_we_drop", 64'(node_we_o), 64'd0);
    check_output("node_pulses", 64'(node_cnt - base), 64'd1);
    bus_read("rd_node", 32'h3004_0005, 32'h0);

    // LEAF lower/upper pair at entry 3.
    base = leaf_cnt;
    apply_stimulus("leaf_lo", 32'h3002_0018, 32'hA5A5_A5A5);
    check_output("leaf_lo_no_we", 64'(leaf_we_o), 64'd0);
    tick();
    apply_stimulus("leaf_hi", 32'h3002_001C, 32'h0000_01FF);
    check_output("leaf_we",    64'(leaf_we_o),   64'd1);
    check_output("leaf_addr",  64'(leaf_addr_o), 64'd3);
    check_output("leaf_wdata", leaf_wdata_o,     64'h0000_01FF_A5A5_A5A5);
    tick();
    check_output("leaf_pulses", 64'(leaf_cnt - base), 64'd1);

    // QUERY upper-only after reset, then two lower writes (last wins), then hold cleared.
    base = query_cnt;
    apply_stimulus("q_hi_only", 32'h3001_0004, 32'h0012_3456);
    check_output("q_we",    64'(query_we_o),    64'd1);
    check_output("q_addr",  64'(query_addr_o),  64'd0);
    check_output("q_wdata", 64'(query_wdata_o), 64'h0012_3456_0000_0000);
    tick();
    apply_stimulus("q_lo1", 32'h3001_0010, 32'h1111_1111);
    tick();
    apply_stimulus("q_lo2", 32'h3001_0010, 32'h2222_2222);
    tick();
    apply_stimulus("q_hi2", 32'h3001_0014, 32'h0000_0000);
    check_output("q_addr2",  64'(query_addr_o),  64'd2);
    check_output("q_wdata2", 64'(query_wdata_o), 64'h0000_0000_2222_2222);
    tick();
    apply_stimulus("q_hi3", 32'h3001_0014, 32'h0000_0001);
    check_output("q_wdata3", 64'(query_wdata_o), 64'h0000_0001_0000_0000);
    tick();
    check_output("q_pulses", 64'(query_cnt - base), 64'd3);

    // BEST read: low half at entry 4 with two-cycle latency.
    bus_start(1'b0, 32'h3003_0020, 32'h0);
    #1;
    check_output("best_re",   64'(best_re_o),   64'd1);
    check_output("best_addr", 64'(best_addr_o), 64'd4);
    tick();
    check_output("best_ack_wait", 64'(wbs_ack_o), 64'd0);
    check_output("best_re_once",  64'(best_re_o), 64'd0);
    tick();
    check_output("best_ack", 64'(wbs_ack_o), 64'd1);
    check_output("best_lo",  64'(wbs_dat_o), 64'h3E8);
    bus_stop();
    tick();
    check_output("best_dat_idle", 64'(wbs_dat_o), 64'd0);

    bus_start(1'b0, 32'h3003_0024, 32'h0);
    repeat (2) tick();
    check_output("best_hi_ack", 64'(wbs_ack_o), 64'd1);
    check_output("best_hi",     64'(wbs_dat_o), 64'h7);
    bus_stop();
    tick();
    apply_stimulus("best_wr", 32'h3003_0000, 32'hDEAD_BEEF);
    tick();

    // Unmapped region/offset: acked, zero data, no side effects.
    bus_read("rd_unmapped", 32'h3005_0000, 32'h0);
    bus_read("rd_bad_off",  32'h3000_0014, 32'h0);
    apply_stimulus("wr_unmapped", 32'h3005_0000, 32'h1);
    tick();

    // DONE: sticky set, write clears, set wins over a same-cycle clear.
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0;
    bus_read("done_set", 32'h3000_0008, 32'h1);
    apply_stimulus("done_clr", 32'h3000_0008, 32'h0);
    tick();
    bus_read("done_cleared", 32'h3000_0008, 32'h0);
    bus_start(1'b1, 32'h3000_0008, 32'h0);
    fsm_done_i = 1'b1;
    tick();
    fsm_done_i = 1'b0;
    bus_stop();
    tick();
    bus_read("done_set_wins", 32'h3000_0008, 32'h1);

    // FSM_START pulse, then suppressed while busy.
    base = start_cnt;
    apply_stimulus("start", 32'h3000_000C, 32'h1);
    check_output("start_pulse", 64'(fsm_start_o), 64'd1);
    tick();
    check_output("start_drop", 64'(fsm_start_o), 64'd0);
    fsm_busy_i = 1'b1;
    apply_stimulus("start_busy", 32'h3000_000C, 32'h1);
    check_output("start_busy_none", 64'(fsm_start_o), 64'd0);
    tick();
    check_output("start_pulses", 64'(start_cnt - base), 64'd1);
    bus_read("rd_busy", 32'h3000_0010, 32'h1);
    fsm_busy_i = 1'b0;

    // Reset while a BEST read is pending: no ack, registers back to zero.
    bus_start(1'b0, 32'h3003_0020, 32'h0);
    tick();
    wb_rst_i = 1'b1;
    tick();
    check_output("midrst_ack", 64'(wbs_ack_o), 64'd0);
    check_output("midrst_dat", 64'(wbs_dat_o), 64'd0);
    bus_stop();
    wb_rst_i = 1'b0;
    tick();
    check_output("midrst_ack_after", 64'(wbs_ack_o), 64'd0);
    check_output("midrst_mode",      64'(mode_o),    64'd0);
    check_output("midrst_debug",     64'(debug_o),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
